// File: rtl/bullet_slot_arbiter.sv
// bullet_slot_arbiter: shares a pool of bullet slots among fire requesters.
// Requester 0 is the player, 1..NUM_REQ-1 are enemy emitters. A round-robin
// arbiter hands out the lowest free slot. External reports free slots, and a
// bomb sweep frees every enemy-owned slot.
// Optional feature macro: BULLET_COOLDOWN_EN adds a per-requester cooldown
// counter. In the default build a requester is masked only in the cycle that
// follows its own grant.
module bullet_slot_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_SLOTS = 16,
    parameter int SLOT_W    = 4,
    parameter int COOLDOWN  = 8
) (
    input  logic                 clk,
    input  logic                 hard_reset,
    input  logic                 game_en,
    input  logic                 game_reset,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic [SLOT_W-1:0]    grant_slot,
    input  logic                 free_valid,
    input  logic [SLOT_W-1:0]    free_slot,
    input  logic                 bomb_clear,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic [SLOT_W:0]      busy_count,
    output logic                 full,
    output logic                 sweep_busy
);

    localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                          state, state_nxt;
    logic [SLOT_W-1:0]               idx, idx_nxt;
    logic [REQ_W-1:0]                rr_ptr, rr_nxt;
    logic [NUM_SLOTS-1:0][REQ_W-1:0] owner;

    logic [NUM_REQ-1:0]   cd_zero;
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [REQ_W-1:0]     win, cand;
    logic                 found;
    logic [SLOT_W-1:0]    alloc_slot;
    logic                 any_free;
    logic                 grant_fire;
    logic                 sweep_free;
    logic [NUM_SLOTS-1:0] busy_nxt;
    logic [SLOT_W:0]      cnt_nxt;

    assign full       = (busy_count == (SLOT_W+1)'(NUM_SLOTS));
    assign sweep_busy = (state == SWEEP);

`ifdef BULLET_COOLDOWN_EN
    localparam int CD_W = $clog2(COOLDOWN + 1);

    logic [NUM_REQ-1:0][CD_W-1:0] cd;

    // Cooldown counters: load on grant, count down only while the game runs.
    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            cd <= '0;
        end else if (game_reset) begin
            cd <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (grant_nxt[r])
                    cd[r] <= CD_W'(COOLDOWN);
                else if (game_en && cd[r] != '0)
                    cd[r] <= cd[r] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++)
            cd_zero[r] = (cd[r] == '0);
    end
`else
    // Without cooldown counters every requester is always past its cooldown.
    assign cd_zero = '1;
`endif

    // Arbitration, slot allocation, sweep release and next bitmap/count.
    always_comb begin
        elig = req & ~grant & cd_zero;

        // round-robin: first eligible requester at or above the pointer
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = REQ_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        // lowest free slot, taken from the bitmap before this cycle's frees
        any_free   = 1'b0;
        alloc_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                any_free   = 1'b1;
                alloc_slot = SLOT_W'(i);
            end
        end

        grant_fire = (state == IDLE) && game_en && !bomb_clear && !full
                     && found && any_free;
        grant_nxt = '0;
        if (grant_fire)
            grant_nxt[win] = 1'b1;
        rr_nxt = grant_fire ? REQ_W'((int'(win) + 1) % NUM_REQ) : rr_ptr;

        sweep_free = (state == SWEEP) && game_en && slot_busy[idx]
                     && (owner[idx] != '0);

        // clearing an already-free bit, or the same bit twice, is harmless
        busy_nxt = slot_busy;
        if (free_valid)
            busy_nxt[free_slot] = 1'b0;
        if (sweep_free)
            busy_nxt[idx] = 1'b0;
        if (grant_fire)
            busy_nxt[alloc_slot] = 1'b1;

        cnt_nxt = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            cnt_nxt = cnt_nxt + {{SLOT_W{1'b0}}, busy_nxt[i]};

        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (bomb_clear && game_en) begin
                    state_nxt = SWEEP;
                    idx_nxt   = '0;
                end
            end
            SWEEP: begin
                if (game_en) begin
                    if (idx == SLOT_W'(NUM_SLOTS - 1)) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointer, pool and registered grant; game_reset wins over all.
    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            state      <= IDLE;
            idx        <= '0;
            rr_ptr     <= '0;
            owner      <= '0;
            grant      <= '0;
            grant_slot <= '0;
            slot_busy  <= '0;
            busy_count <= '0;
        end else if (game_reset) begin
            state      <= IDLE;
            idx        <= '0;
            rr_ptr     <= '0;
            owner      <= '0;
            grant      <= '0;
            grant_slot <= '0;
            slot_busy  <= '0;
            busy_count <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            rr_ptr     <= rr_nxt;
            grant      <= grant_nxt;
            grant_slot <= grant_fire ? alloc_slot : '0;
            slot_busy  <= busy_nxt;
            busy_count <= cnt_nxt;
            if (grant_fire)
                owner[alloc_slot] <= win;
        end
    end

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Scoreboard bench for bullet_slot_arbiter: stimulus pushes expected grants,
// a negedge monitor pops and compares whenever a grant appears.
module tb_bullet_slot_arbiter;

    logic        clk = 1'b0;
    logic        hard_reset;
    logic        game_en;
    logic        game_reset;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [3:0]  grant_slot;
    logic        free_valid;
    logic [3:0]  free_slot;
    logic        bomb_clear;
    logic [15:0] slot_busy;
    logic [4:0]  busy_count;
    logic        full;
    logic        sweep_busy;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [3:0] mask;
        logic [3:0] slot;
    } exp_t;

    exp_t q[$];
    exp_t e;

    bullet_slot_arbiter #(.NUM_REQ(4), .NUM_SLOTS(16), .SLOT_W(4), .COOLDOWN(8)) dut (
        .clk(clk), .hard_reset(hard_reset), .game_en(game_en), .game_reset(game_reset),
        .req(req), .grant(grant), .grant_slot(grant_slot),
        .free_valid(free_valid), .free_slot(free_slot), .bomb_clear(bomb_clear),
        .slot_busy(slot_busy), .busy_count(busy_count), .full(full), .sweep_busy(sweep_busy)
    );

    always #5 clk = ~clk;

    // Monitor: every visible grant must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!hard_reset && grant != 4'b0) begin
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: got grant=%b slot=%0d, required no grant", grant, grant_slot);
            end else begin
                e = q.pop_front();
                if ($countones(grant) != 1 || (grant & ~e.mask) != 4'b0 || grant_slot != e.slot) begin
                    errors++;
                    $display("FAIL grant: got grant=%b slot=%0d, required one-hot within %b slot=%0d",
                             grant, grant_slot, e.mask, e.slot);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_game_reset();
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
    endtask

    // Hold r until a grant shows up (bounded), expecting emask/slot.
    task automatic grant_one(input logic [3:0] r, input logic [3:0] emask, input logic [3:0] slot);
        bit got = 0;
        q.push_back('{mask: emask, slot: slot});
        req = r;
        for (int i = 0; i < 30; i++) begin
            step();
            if (grant != 4'b0) begin
                got = 1;
                break;
            end
        end
        req = 4'b0;
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: got no grant for req=%b, required slot %0d", r, slot);
        end
    endtask

    initial begin
        int n;
        int t;
        int times[2];

        hard_reset = 1'b1;
        game_en    = 1'b1;
        game_reset = 1'b0;
        req        = '0;
        free_valid = 1'b0;
        free_slot  = '0;
        bomb_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant", grant, 0);
        check("reset_slot_busy", slot_busy, 0);
        check("reset_busy_count", busy_count, 0);
        check("reset_full_sweep", {full, sweep_busy}, 0);
        hard_reset = 1'b0;
        step();

        // single player request
        grant_one(4'b0001, 4'b0001, 4'd0);
        check("first_busy_count", busy_count, 1);

        // all four requesting, round-robin order 0,1,2,3
        pulse_game_reset();
        q.push_back('{mask: 4'b0001, slot: 4'd0});
        q.push_back('{mask: 4'b0010, slot: 4'd1});
        q.push_back('{mask: 4'b0100, slot: 4'd2});
        q.push_back('{mask: 4'b1000, slot: 4'd3});
        req = 4'b1111;
        repeat (4) step();
        req = 4'b0;
        step();
        check("rr_slot_busy", slot_busy, 16'h000F);
        check("rr_busy_count", busy_count, 4);
        // pointer has wrapped to 0: of {1,3}, requester 1 wins
        grant_one(4'b1010, 4'b0010, 4'd4);

        // fill the pool
        pulse_game_reset();
        for (int i = 0; i < 16; i++)
            q.push_back('{mask: 4'b1111, slot: i[3:0]});
        req = 4'b1111;
        for (int i = 0; i < 200; i++) begin
            step();
            if (busy_count == 5'd16) break;
        end
        req = 4'b0;
        check("fill_count", busy_count, 16);
        req = 4'b0010;
        repeat (12) step();
        check("full_flag", full, 1);
        check("full_slot_busy", slot_busy, 16'hFFFF);
        q.push_back('{mask: 4'b0010, slot: 4'd5});
        free_valid = 1'b1;
        free_slot  = 4'd5;
        step();
        free_valid = 1'b0;
        check("free_while_full_count", busy_count, 15);
        step();
        req = 4'b0;
        check("refill_count", busy_count, 16);

        // bomb sweep over owners {0,1,0,2}
        pulse_game_reset();
        grant_one(4'b0001, 4'b0001, 4'd0);
        grant_one(4'b0010, 4'b0010, 4'd1);
        grant_one(4'b0001, 4'b0001, 4'd2);
        grant_one(4'b0100, 4'b0100, 4'd3);
        bomb_clear = 1'b1;
        step();
        bomb_clear = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!sweep_busy) break;
            n++;
            step();
        end
        check("sweep_cycles", n, 16);
        check("sweep_slot_busy", slot_busy, 16'h0005);
        check("sweep_busy_count", busy_count, 2);

        // free slot 0 while allocating: slot 0 must not be reused
        q.push_back('{mask: 4'b0001, slot: 4'd1});
        free_valid = 1'b1;
        free_slot  = 4'd0;
        req        = 4'b0001;
        step();
        free_valid = 1'b0;
        req        = 4'b0;
        check("free_alloc_slot_busy", slot_busy, 16'h0006);
        check("free_alloc_count", busy_count, 2);
        free_valid = 1'b1;
        free_slot  = 4'd0;
        step();
        free_valid = 1'b0;
        check("free_of_free_count", busy_count, 2);
        check("free_of_free_popcount", $countones(slot_busy), 2);

        // game_reset in the middle of a sweep
        grant_one(4'b0100, 4'b0100, 4'd0);
        bomb_clear = 1'b1;
        step();
        bomb_clear = 1'b0;
        step();
        check("mid_sweep_busy", sweep_busy, 1);
        pulse_game_reset();
        check("greset_slot_busy", slot_busy, 0);
        check("greset_sweep_busy", sweep_busy, 0);
        check("greset_count", busy_count, 0);

        // game_en=0 freezes arbitration
        game_en = 1'b0;
        req     = 4'b0001;
        repeat (3) step();
        check("frozen_count", busy_count, 0);
        q.push_back('{mask: 4'b0001, slot: 4'd0});
        game_en = 1'b1;
        step();
        req = 4'b0;
        check("unfrozen_count", busy_count, 1);

        // grant spacing for a held player request
        pulse_game_reset();
        q.push_back('{mask: 4'b0001, slot: 4'd0});
        q.push_back('{mask: 4'b0001, slot: 4'd1});
        req      = 4'b0001;
        t        = 0;
        n        = 0;
        times[0] = 0;
        times[1] = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            t++;
            if (grant[0]) begin
                times[n] = t;
                n++;
                if (n == 2) break;
            end
        end
        req = 4'b0;
`ifdef BULLET_COOLDOWN_EN
        check("grant_spacing", times[1] - times[0], 9);
`else
        check("grant_spacing", times[1] - times[0], 2);
`endif

        repeat (3) step();
        check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
